fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready handshake.
- Buffers in-order responses in a small queue and presents one {pc, instr} per cycle to decode.
- Handles branch/jump redirects, pipeline stalls, and the decoder's pause (ECALL/EBREAK/FENCE) by halting until resumed.

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: sequential PC issue, in-order response queue, redirect and pause/HALT handling.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / bubble_cnt performance counter ports.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        pause,
    input  logic        resume,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t        state;
    logic          started;
    logic [31:0]   pc;
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   pf_pc   [QDEPTH];
    logic [AW-1:0] q_rd, q_wr, pf_rd, pf_wr;
    logic [CW-1:0] q_cnt, inflight, drop, inflight_nxt;

    logic pause_take, flush, resp_take, push, pop, req_fire, space_ok;

    // Request handshake: a request transfers on any cycle with imem_req_valid && imem_req_ready;
    // responses come back in request order, one per imem_resp_valid cycle.
    assign if_valid   = (q_cnt != '0);
    assign if_instr   = if_valid ? q_instr[q_rd] : 32'h0;
    assign if_pc      = if_valid ? q_pc[q_rd] : 32'h0;
    assign halted     = (state == S_HALT);

    assign pause_take = pause && if_valid && !redirect_valid;
    assign flush      = redirect_valid || pause_take;
    assign resp_take  = imem_resp_valid && (inflight != '0);
    assign push       = resp_take && (drop == '0) && !flush;
    assign pop        = if_valid && !stall && !flush;
    assign space_ok   = ({1'b0, q_cnt} + {1'b0, inflight}) < QD;

    assign imem_req_valid = started && (state == S_RUN) && !redirect_valid && !pause_take && space_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inflight_nxt   = inflight + CW'(req_fire) - CW'(resp_take);

    // Storage arrays carry no reset; occupancy and pointers decide what is meaningful.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pf_pc[pf_wr] <= pc;
        end
        if (push) begin
            q_instr[q_wr] <= imem_resp_data;
            q_pc[q_wr]    <= pf_pc[pf_rd];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            started  <= 1'b0;
            pc       <= RESET_PC;
            q_rd     <= '0;
            q_wr     <= '0;
            pf_rd    <= '0;
            pf_wr    <= '0;
            q_cnt    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            started  <= 1'b1;
            inflight <= inflight_nxt;

            if (req_fire) begin
                pf_wr <= pf_wr + 1'b1;
                pc    <= pc + 32'd4;
            end
            if (resp_take) begin
                pf_rd <= pf_rd + 1'b1;
                if (drop != '0) begin
                    drop <= drop - CW'(1);
                end
            end

            if (flush) begin
                q_rd  <= q_wr;
                q_cnt <= '0;
            end else begin
                if (push) begin
                    q_wr <= q_wr + 1'b1;
                end
                if (pop) begin
                    q_rd <= q_rd + 1'b1;
                end
                q_cnt <= q_cnt + CW'(push) - CW'(pop);
            end

            if (state == S_HALT && resume) begin
                state <= S_RUN;
            end

            // Everything still in flight after this edge belongs to the abandoned stream.
            if (redirect_valid) begin
                pc   <= redirect_pc & 32'hFFFF_FFFC;
                drop <= inflight_nxt;
            end else if (pause_take) begin
                pc    <= if_pc + 32'd4;
                drop  <= inflight_nxt;
                state <= S_HALT;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= 32'h0;
            bubble_cnt <= 32'h0;
        end else begin
            if (if_valid && !stall) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (!if_valid && state == S_RUN && !stall) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: transaction-level queue model checked every cycle, plus literal
// expectations on the delivered PC/instruction and request streams.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        pause;
    logic        resume;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .pause          (pause),
        .resume         (resume),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .bubble_cnt     (bubble_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_pend[$];
    int          m_drop    = 0;
    logic [31:0] m_pc      = RESET_PC;
    bit          m_halt    = 1'b0;
    bit          m_started = 1'b0;
    logic [31:0] m_fetch   = 32'h0;
    logic [31:0] m_bubble  = 32'h0;

    logic [31:0] mem_q[$];
    bit          mem_hold = 1'b0;
    logic [31:0] req_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_instr[$];

    bit          e_ifv, e_pause, e_req;
    logic [63:0] e_head;
    logic [31:0] rpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h20) return 32'h0000_0073;
        if (a < 32'h10) return 32'h0000_0013;
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind 0: delivered pc, 1: delivered instr, 2: request address
    task automatic chk_at(input string name, input int kind, input int idx, input logic [31:0] exp);
        int sz;
        sz = (kind == 0) ? del_pc.size() : (kind == 1) ? del_instr.size() : req_log.size();
        if (idx < sz) begin
            chk(name, (kind == 0) ? del_pc[idx] : (kind == 1) ? del_instr[idx] : req_log[idx], exp);
        end else begin
            n_checks++;
            n_err++;
            $display("FAIL %s: entry %0d missing, expected %h", name, idx, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    always @(posedge clk) begin
        #2;
        if (!mem_hold && mem_q.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    end

    // ---------------- model + per-cycle compare ----------------
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_pend.delete();
            m_drop    = 0;
            m_pc      = RESET_PC;
            m_halt    = 1'b0;
            m_started = 1'b0;
            m_fetch   = 32'h0;
            m_bubble  = 32'h0;
            if (!clk) begin
                chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
                chk("rst_if_valid", 32'(if_valid), 32'h0);
                chk("rst_if_instr", if_instr, 32'h0);
                chk("rst_if_pc", if_pc, 32'h0);
                chk("rst_halted", 32'(halted), 32'h0);
            end
        end else begin
            e_ifv   = exp_q.size() > 0;
            e_head  = e_ifv ? exp_q[0] : 64'h0;
            e_pause = pause && e_ifv && !redirect_valid;
            e_req   = m_started && !m_halt && !redirect_valid && !e_pause
                      && (exp_q.size() + m_pend.size() < QDEPTH);

            chk("req_valid", 32'(imem_req_valid), 32'(e_req));
            if (e_req) chk("req_addr", imem_req_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(e_ifv));
            chk("if_instr", if_instr, e_head[31:0]);
            if (e_ifv) chk("if_pc", if_pc, e_head[63:32]);
            chk("halted", 32'(halted), 32'(m_halt));
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_cnt", fetch_cnt, m_fetch);
            chk("bubble_cnt", bubble_cnt, m_bubble);
`endif

            if (imem_req_valid && imem_req_ready) begin
                req_log.push_back(imem_req_addr);
                mem_q.push_back(imem_req_addr);
            end
            if (if_valid && !stall) begin
                del_pc.push_back(if_pc);
                del_instr.push_back(if_instr);
            end

            if (e_ifv && !stall) begin
                void'(exp_q.pop_front());
                m_fetch = m_fetch + 32'd1;
            end
            if (!e_ifv && !m_halt && !stall) m_bubble = m_bubble + 32'd1;
            if (imem_resp_valid && m_pend.size() > 0) begin
                rpc = m_pend.pop_front();
                if (m_drop > 0) m_drop--;
                else exp_q.push_back({rpc, imem_resp_data});
            end
            if (e_req && imem_req_ready) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (m_halt && resume) m_halt = 1'b0;
            if (redirect_valid) begin
                exp_q.delete();
                m_pc   = {redirect_pc[31:2], 2'b00};
                m_drop = m_pend.size();
            end else if (e_pause) begin
                exp_q.delete();
                m_pc   = e_head[63:32] + 32'd4;
                m_drop = m_pend.size();
                m_halt = 1'b1;
            end
            m_started = 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] rdy_pat = 12'b1010_0111_0110;
    int d0, d3, d5, d6, d7, r4, r7;

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        pause          = 1'b0;
        resume         = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // basic sequential fetch
        repeat (10) tick();
        chk_at("t1_req0", 2, 0, 32'h0);
        chk_at("t1_req1", 2, 1, 32'h4);
        chk_at("t1_req2", 2, 2, 32'h8);
        chk_at("t1_pc0", 0, 0, 32'h0);
        chk_at("t1_pc1", 0, 1, 32'h4);
        chk_at("t1_pc2", 0, 2, 32'h8);
        chk_at("t1_instr0", 1, 0, 32'h0000_0013);
        chk_at("t1_instr2", 1, 2, 32'h0000_0013);

        // stall fills the queue, then drains without loss or duplication
        d0 = del_pc.size();
        stall = 1'b1;
        repeat (5) tick();
        chk("t2_full_noreq", 32'(imem_req_valid), 32'h0);
        chk("t2_head_valid", 32'(if_valid), 32'h1);
        stall = 1'b0;
        repeat (8) tick();
        chk("t2_progress", 32'(del_pc.size() >= d0 + 3), 32'h1);
        for (int i = 0; i < del_pc.size(); i++) chk("t2_seq", del_pc[i], 32'(i * 4));

        // two requests in flight, then redirect (low bits of target ignored)
        mem_hold = 1'b1;
        repeat (4) tick();
        chk("t3_no_space", 32'(imem_req_valid), 32'h0);
        chk("t3_empty", 32'(if_valid), 32'h0);
        d3 = del_pc.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0101;
        tick();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        repeat (8) tick();
        chk_at("t3_first_pc", 0, d3, 32'h100);
        chk_at("t3_first_instr", 1, d3, 32'h0001_0013);
        chk_at("t3_second_pc", 0, d3 + 1, 32'h104);

        // pause on ECALL at 0x20, hold in HALT, resume at 0x24
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        stall          = 1'b1;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        chk("t4_head_pc", if_pc, 32'h20);
        chk("t4_head_instr", if_instr, 32'h0000_0073);
        pause = 1'b1;
        tick();
        pause = 1'b0;
        stall = 1'b0;
        r4 = req_log.size();
        repeat (10) tick();
        chk("t4_halted", 32'(halted), 32'h1);
        chk("t4_no_req", 32'(req_log.size()), 32'(r4));
        resume = 1'b1;
        tick();
        resume = 1'b0;
        repeat (4) tick();
        chk("t4_running", 32'(halted), 32'h0);
        chk_at("t4_resume_req", 2, r4, 32'h24);

        // redirect and pause together: redirect wins; resume while running does nothing
        stall = 1'b1;
        repeat (3) tick();
        d5 = del_pc.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        pause          = 1'b1;
        tick();
        redirect_valid = 1'b0;
        pause          = 1'b0;
        stall          = 1'b0;
        chk("t5_not_halted", 32'(halted), 32'h0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        repeat (6) tick();
        chk_at("t5_first_pc", 0, d5, 32'h40);
        chk_at("t5_second_pc", 0, d5 + 1, 32'h44);

        // PC wrap with an irregular ready pattern
        d6 = del_pc.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            imem_req_ready = rdy_pat[i];
            tick();
        end
        imem_req_ready = 1'b1;
        repeat (6) tick();
        chk_at("t6_pc_fff8", 0, d6, 32'hFFFF_FFF8);
        chk_at("t6_pc_fffc", 0, d6 + 1, 32'hFFFF_FFFC);
        chk_at("t6_pc_wrap", 0, d6 + 2, 32'h0);

        // reset pulse with one request in flight; its late response is ignored
        imem_req_ready = 1'b0;
        repeat (4) tick();
        mem_hold       = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        mem_hold       = 1'b0;
        d7 = del_pc.size();
        r7 = req_log.size();
        repeat (8) tick();
        chk_at("t7_req_reset_pc", 2, r7, RESET_PC);
        chk_at("t7_first_pc", 0, d7, RESET_PC);
        chk_at("t7_first_instr", 1, d7, 32'h0000_0013);
        chk_at("t7_second_pc", 0, d7 + 1, RESET_PC + 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
